mem_stage: RTL

- MEM pipeline stage between EX and WB.
- Issues load/store requests (word or signed-byte loads; word or byte stores) to the data cache with a req/ready handshake, stalling upstream while a request is outstanding.
- Registers the MEM/WB bundle that the write-back mux consumes: raw cache bytes, byte_number, is_word, ALU/FPU results, register-source selects, rd number, halt flag.
- Non-memory instructions pass through in one cycle.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mem_store_align.sv | 33 +++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MEM-stage types, register-source selects and lane helper
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } mem_state_t;

  // Four byte lanes; lane 3 carries word bits [31:24], lane 0 carries [7:0].
  typedef logic [7:0] byte_lanes_t [0:3];

  // Integer register-file write source.
  localparam logic [1:0] REG_SRC_ALU  = 2'b00;
  localparam logic [1:0] REG_SRC_MEM  = 2'b01;
  localparam logic [1:0] REG_SRC_PC4  = 2'b10;
  localparam logic [1:0] REG_SRC_FALU = 2'b11;

  // Floating-point register-file write source.
  localparam logic [1:0] FREG_SRC_FALU = 2'b00;
  localparam logic [1:0] FREG_SRC_MEM  = 2'b01;
  localparam logic [1:0] FREG_SRC_RS   = 2'b10;

  // Big-endian: byte 0 of a word lives in lane 3.
  function automatic logic [1:0] lane_of(input logic [1:0] byte_number);
    return 2'd3 - byte_number;
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// rtl/mem_store_align.sv - store byte-enable and write-lane generation
// Ports:
//   is_word_i   1 = word store, 0 = byte store
//   byte_num_i  address bits [1:0]
//   rt_data_i   store data (byte stores use [7:0])
//   byte_en_o   per-lane write enable
//   wdata_o     write data per lane, unused lanes zero
module mem_store_align
  import mips_pkg::*;
(
  input  logic        is_word_i,
  input  logic [1:0]  byte_num_i,
  input  logic [31:0] rt_data_i,
  output logic [3:0]  byte_en_o,
  output logic [7:0]  wdata_o [0:3]
);

  always_comb begin
    byte_en_o = 4'b0000;
    wdata_o   = '{default: 8'h00};
    if (is_word_i) begin
      byte_en_o  = 4'b1111;
      wdata_o[3] = rt_data_i[31:24];
      wdata_o[2] = rt_data_i[23:16];
      wdata_o[1] = rt_data_i[15:8];
      wdata_o[0] = rt_data_i[7:0];
    end else begin
      byte_en_o[lane_of(byte_num_i)] = 1'b1;
      wdata_o[lane_of(byte_num_i)]   = rt_data_i[7:0];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-cache handshake and MEM/WB register
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   valid_in .. halted_in      EX/MEM bundle
//   cache_*                    data-cache request (req/ready handshake, byte lanes)
//   stall                      holds EX/ID/IF while a request is being issued or waited on
//   *_wb                       MEM/WB bundle for the write-back mux
//   misalign_err, timeout_err, halted_controller  sticky status flags
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        is_word_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] rt_data_in,
  input  logic [31:0] fALU_result_in,
  input  logic [31:0] rs_data_in,
  input  logic [31:0] inst_addr_in,
  input  logic [1:0]  register_src_in,
  input  logic [1:0]  fregister_src_in,
  input  logic [4:0]  rd_num_in,
  input  logic        halted_in,
  output logic        cache_req,
  output logic        cache_we,
  output logic [31:0] cache_addr,
  output logic [3:0]  cache_byte_en,
  output logic [7:0]  cache_wdata [0:3],
  input  logic        cache_ready,
  input  logic [7:0]  cache_rdata [0:3],
  output logic        stall,
  output logic        valid_wb,
  output logic        is_word_wb,
  output logic        halted_wb,
  output logic [1:0]  byte_number_wb,
  output logic [1:0]  register_src_wb,
  output logic [1:0]  fregister_src_wb,
  output logic [4:0]  rd_num_wb,
  output logic [31:0] ALU_result_wb,
  output logic [31:0] fALU_result_wb,
  output logic [31:0] rs_data_wb,
  output logic [31:0] inst_addr_wb,
  output logic [7:0]  cache_data_out_wb [0:3],
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        halted_controller
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_mem;
  logic             misalign;
  logic             timeout_hit;
  logic             latch_wb;
  logic             issue;
  logic [3:0]       st_byte_en;
  byte_lanes_t      st_wdata;

  mem_store_align u_store_align (
    .is_word_i  (is_word_in),
    .byte_num_i (ALU_result_in[1:0]),
    .rt_data_i  (rt_data_in),
    .byte_en_o  (st_byte_en),
    .wdata_o    (st_wdata)
  );

  always_comb begin
    is_mem      = mem_read_in | mem_write_in;
    misalign    = is_mem & is_word_in & (ALU_result_in[1:0] != 2'b00);
    timeout_hit = (cnt_q == CNT_LAST) & ~cache_ready;
    latch_wb    = 1'b0;
    issue       = 1'b0;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A misaligned access is dropped without touching the WB bundle.
        latch_wb = valid_in & (halted_in | ~misalign);
        issue    = valid_in & ~halted_in & is_mem & ~misalign;
        stall    = issue;
      end
      // Release on the abort cycle too, so the aborted op is not re-presented.
      S_WAIT:  stall = ~(cache_ready | timeout_hit);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      cache_req         <= 1'b0;
      cache_we          <= 1'b0;
      cache_addr        <= '0;
      cache_byte_en     <= '0;
      cache_wdata       <= '{default: 8'h00};
      valid_wb          <= 1'b0;
      is_word_wb        <= 1'b0;
      halted_wb         <= 1'b0;
      byte_number_wb    <= '0;
      register_src_wb   <= '0;
      fregister_src_wb  <= '0;
      rd_num_wb         <= '0;
      ALU_result_wb     <= '0;
      fALU_result_wb    <= '0;
      rs_data_wb        <= '0;
      inst_addr_wb      <= '0;
      cache_data_out_wb <= '{default: 8'h00};
      misalign_err      <= 1'b0;
      timeout_err       <= 1'b0;
      halted_controller <= 1'b0;
    end else begin
      if (latch_wb) begin
        is_word_wb        <= is_word_in;
        halted_wb         <= halted_in;
        byte_number_wb    <= ALU_result_in[1:0];
        register_src_wb   <= register_src_in;
        fregister_src_wb  <= fregister_src_in;
        rd_num_wb         <= rd_num_in;
        ALU_result_wb     <= ALU_result_in;
        fALU_result_wb    <= fALU_result_in;
        rs_data_wb        <= rs_data_in;
        inst_addr_wb      <= inst_addr_in;
        cache_data_out_wb <= '{default: 8'h00};
      end
      case (state_q)
        S_IDLE: begin
          // Memory ops issue as a bubble; they become valid on completion.
          valid_wb <= valid_in & (halted_in | ~is_mem);
          if (valid_in & halted_in) begin
            halted_controller <= 1'b1;
            state_q           <= S_HALT;
          end else if (valid_in & misalign) begin
            misalign_err <= 1'b1;
          end else if (issue) begin
            cache_req     <= 1'b1;
            cache_we      <= mem_write_in;
            cache_addr    <= {ALU_result_in[31:2], 2'b00};
            cache_byte_en <= mem_write_in ? st_byte_en : 4'b0000;
            cache_wdata   <= mem_write_in ? st_wdata : '{default: 8'h00};
            cnt_q         <= '0;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          valid_wb <= cache_ready;
          if (cache_ready) begin
            if (!cache_we) cache_data_out_wb <= cache_rdata;
            cache_req <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_err <= 1'b1;
            cache_req   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: valid_wb <= 1'b0;
      endcase
    end
  end

endmodule
